pc_next_unit: RTL
=================

# pc_next_unit

Program-counter and branch-resolution stage sitting directly downstream of the 8-bit ALU. It consumes the ALU's `jump` and `zero` flags together with decoded branch controls, and produces the registered instruction address for fetch. It also holds a 16-entry absolute branch-target lookup table, a run/halt state machine, and a retired-cycle counter used by the test harness to detect program completion.

## Interface
Parameters:
- `pc_width`, 10, instruction address width
- `reg_width`, 8, ALU data width; width of the relative offset
- `lut_aw`, 4, branch LUT index width (2^lut_aw entries)
- `start_addr`, 0, PC value loaded on reset and on `start`

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`
- `start`  in  1  one-cycle pulse; leaves IDLE or HALTED and begins execution
- `stall`  in  1  freezes PC, counter and state for this cycle
- `halt_req`  in  1  decoded halt instruction
- `branch_en`  in  1  current instruction is a conditional branch
- `br_sel`  in  1  branch condition: 0 = ALU `jump`, 1 = ALU `zero`
- `branch_rel`  in  1  1 = PC-relative target, 0 = absolute target from LUT
- `jump`  in  1  ALU jump flag
- `zero`  in  1  ALU zero flag
- `offset`  in  reg_width  signed two's-complement relative displacement
- `lut_idx`  in  lut_aw  LUT read index for absolute branches
- `lut_we`  in  1  LUT write enable
- `lut_waddr`  in  lut_aw  LUT write index
- `lut_wdata`  in  pc_width  LUT write data
- `pc_out`  out  pc_width  registered current instruction address
- `running`  out  1  high in RUN
- `done`  out  1  high in HALTED
- `cycle_count`  out  16  non-stalled RUN cycles since last `start`

## Operation
- States: IDLE, RUN, HALTED. Reset → IDLE.
- Reset values: `pc_out` = `start_addr`, `running` = 0, `done` = 0, `cycle_count` = 0, all LUT entries = 0.
- IDLE: `start` → RUN, `pc_out` = `start_addr`, `cycle_count` = 0. All other inputs are ignored.
- RUN, `stall` = 1: all state holds. Stall overrides `halt_req`, branch and `start`.
- RUN, `stall` = 0, priority order:
  1. `halt_req` → HALTED; `pc_out` holds; `cycle_count` increments.
  2. `branch_en` and cond (cond = `br_sel` ? `zero` : `jump`):
     - If `branch_rel` = 1: `pc_out` = `pc_out` + sign-extended `offset`, modulo 2^pc_width.
     - If `branch_rel` = 0: `pc_out` = LUT[`lut_idx`].
  3. Otherwise: `pc_out` = `pc_out` + 1, wrapping from 2^pc_width−1 to 0.
  - In cases 2 and 3, `cycle_count` increments.
- `cycle_count` saturates at 0xFFFF and does not wrap.
- `start` while in RUN is ignored.
- HALTED: `done` = 1 and `pc_out` holds. `start` → RUN, with `pc_out` = `start_addr` and `cycle_count` cleared.
- LUT write: when `lut_we` = 1, LUT[`lut_waddr`] ← `lut_wdata`. Writes are accepted in any state, including during `stall`, but not during `reset`.
- LUT read/write collision at the same index in the same cycle: the branch uses the old (pre-write) contents.
- A branch whose condition is false behaves exactly as sequential (+1).

## Timing
- All outputs are registered. Inputs are sampled at edge N; the resulting `pc_out`, `running`, `done` and `cycle_count` are visible after edge N, giving 1-cycle latency.
- `start` sampled at edge N: `running` = 1 and `pc_out` = `start_addr` after edge N; the first increment or branch occurs at edge N+1.
- `halt_req` sampled at edge N: `done` = 1 and `running` = 0 after edge N.
- `reset` at any edge, in any state, returns all state to reset values at that edge. It overrides `start`, `lut_we` and `stall`.
- `jump` and `zero` are combinational ALU outputs and must be stable before the edge. This block adds no registration on them.

## Test plan
- Reset, then pulse `start`, then 5 free-running cycles → `pc_out` steps 0,1,2,3,4,5; `cycle_count` = 5; `running` = 1.
- Relative branch: `pc_out` = 20, `branch_en` = 1, `br_sel` = 0, `jump` = 1, `branch_rel` = 1, `offset` = 8'hFA → next `pc_out` = 14. Repeat with `offset` = 8'h05 and `jump` = 0 → next `pc_out` = 15.
- Absolute LUT branch: write LUT[3] = 10'h2A0, then branch with `br_sel` = 1, `zero` = 1, `lut_idx` = 3 → `pc_out` = 0x2A0. A same-cycle write of LUT[3] = 0x111 during that branch still yields 0x2A0.
- Wrap and stall: `pc_out` = 0x3FF with no branch → 0x000. `stall` held for 3 cycles → `pc_out` and `cycle_count` unchanged. `stall` together with `halt_req` → stays in RUN.
- Halt priority: `halt_req` = 1 with a taken branch in the same cycle → `done` = 1 next cycle and `pc_out` unchanged. Then `start` → `pc_out` = 0, `cycle_count` = 0, `running` = 1.
- Reset mid-run: assert `reset` at `pc_out` = 37 with `cycle_count` = 37 → next cycle IDLE, `pc_out` = 0, `cycle_count` = 0, and LUT[3] reads back 0 on a subsequent absolute branch.

Source files
------------

// File: rtl/pc_next_unit.sv
// Program counter and branch resolution stage with run/halt control.
// Holds the absolute branch-target LUT and the retired-cycle counter.
module pc_next_unit #(
    parameter int pc_width   = 10,
    parameter int reg_width  = 8,
    parameter int lut_aw     = 4,
    parameter int start_addr = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 halt_req,
    input  logic                 branch_en,
    input  logic                 br_sel,
    input  logic                 branch_rel,
    input  logic                 jump,
    input  logic                 zero,
    input  logic [reg_width-1:0] offset,
    input  logic [lut_aw-1:0]    lut_idx,
    input  logic                 lut_we,
    input  logic [lut_aw-1:0]    lut_waddr,
    input  logic [pc_width-1:0]  lut_wdata,
    output logic [pc_width-1:0]  pc_out,
    output logic                 running,
    output logic                 done,
    output logic [15:0]          cycle_count
);

    localparam logic [pc_width-1:0] start_pc = pc_width'(start_addr);
    localparam int lut_depth = 2 ** lut_aw;

    // running/done are decoded registered copies of this state:
    // IDLE = 0/0, RUN = 1/0, HALTED = 0/1.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t              state;
    logic [pc_width-1:0] lut [lut_depth];

    logic                cond;
    logic                taken;
    logic [pc_width-1:0] offset_ext;
    logic [pc_width-1:0] pc_next;

    always_comb begin
        cond       = br_sel ? zero : jump;
        taken      = branch_en && cond;
        offset_ext = {{(pc_width - reg_width){offset[reg_width-1]}}, offset};
        pc_next    = pc_out + 1'b1;
        if (taken) begin
            // The LUT read sees pre-write contents on a same-index collision.
            pc_next = branch_rel ? (pc_out + offset_ext) : lut[lut_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc_out      <= start_pc;
            running     <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
            for (int i = 0; i < lut_depth; i++) begin
                lut[i] <= '0;
            end
        end else begin
            if (lut_we) begin
                lut[lut_waddr] <= lut_wdata;
            end
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state       <= RUN;
                        pc_out      <= start_pc;
                        cycle_count <= '0;
                        running     <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (cycle_count != 16'hFFFF) begin
                            cycle_count <= cycle_count + 16'd1;
                        end
                        if (halt_req) begin
                            state   <= HALTED;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            pc_out <= pc_next;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
